// File: rtl/lowpass_mc_pkg.sv
// ============================================================================
// Module      : lowpass_mc_pkg
// Description : Shared constants, FSM state and pipeline-stage type for the
//               multi-channel lowpass (optional macro LOWPASS_MC_ROUND_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lowpass_mc_pkg;

    localparam int WIDTH_CFG         = 30;
    localparam int NCH_CFG           = 8;
    localparam int MAX_SHIFT_CFG     = 16;
    localparam int DEFAULT_SHIFT_CFG = 16;

    localparam int CH_W  = $clog2(NCH_CFG);
    localparam int SH_W  = $clog2(MAX_SHIFT_CFG + 1);
    localparam int ACC_W = WIDTH_CFG + MAX_SHIFT_CFG;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_clr;
        logic [CH_W-1:0]      ch;
        logic [WIDTH_CFG-1:0] u;
        logic [SH_W-1:0]      shift;
    } stage_t;

endpackage

`default_nettype wire

// File: rtl/lowpass_mc_acc_mem.sv
// ============================================================================
// Module      : lowpass_mc_acc_mem
// Description : NCH x ACC_W accumulator store, one read and one write port,
//               with write-to-read forwarding of the in-flight write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lowpass_mc_acc_mem
    import lowpass_mc_pkg::*;
#(
    parameter int NCH = NCH_CFG
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_addr,
    input  logic [ACC_W-1:0] wr_data,
    input  logic [CH_W-1:0]  rd_addr,
    output logic [ACC_W-1:0] rd_data
);

    logic [ACC_W-1:0] r_mem_q [NCH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem_q[wr_addr] <= wr_data;
        end
    end

    // The write lands one edge late, so a same-channel read must see it now.
    always_comb begin
        rd_data = r_mem_q[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lowpass_mc.sv
// ============================================================================
// Module      : lowpass_mc
// Description : Time-multiplexed multi-channel first-order IIR lowpass with
//               per-channel shift, clear and init sweep. Define
//               LOWPASS_MC_ROUND_EN for rounded, saturated outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lowpass_mc
    import lowpass_mc_pkg::*;
#(
    parameter int WIDTH         = WIDTH_CFG,
    parameter int NCH           = NCH_CFG,
    parameter int MAX_SHIFT     = MAX_SHIFT_CFG,
    parameter int DEFAULT_SHIFT = DEFAULT_SHIFT_CFG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [WIDTH-1:0] in_data,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [SH_W-1:0]  cfg_shift,
    input  logic             clr_valid,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [WIDTH-1:0] out_data
);

    state_t            r_state_q,     w_state_d;
    logic [CH_W-1:0]   r_init_cnt_q,  w_init_cnt_d;
    logic [SH_W-1:0]   r_shift_q [NCH];
    logic [SH_W-1:0]   w_shift_d [NCH];
    stage_t            r_s1_q,        w_s1_d;
    logic              r_s2_valid_q;
    logic              r_s2_clr_q;
    logic [CH_W-1:0]   r_s2_ch_q;
    logic [SH_W-1:0]   r_s2_shift_q;
    logic [ACC_W-1:0]  r_s2_sum_q;
    logic              r_out_valid_q, w_out_valid_d;
    logic [CH_W-1:0]   r_out_ch_q,    w_out_ch_d;
    logic [WIDTH-1:0]  r_out_data_q,  w_out_data_d;

    logic              w_accept;
    logic              w_clr;
    logic [CH_W-1:0]   w_sel_ch;
    logic [SH_W-1:0]   w_cfg_shift;
    logic              w_wr_en;
    logic [CH_W-1:0]   w_wr_addr;
    logic [ACC_W-1:0]  w_wr_data;
    logic [ACC_W-1:0]  w_rd_data;
    logic [ACC_W-1:0]  w_sum_new;
    logic [WIDTH-1:0]  w_result;

    assign in_ready  = (r_state_q == RUN) && !clr_valid;
    assign out_valid = r_out_valid_q;
    assign out_ch    = r_out_ch_q;
    assign out_data  = r_out_data_q;

    assign w_accept    = in_valid && in_ready;
    assign w_clr       = (r_state_q == RUN) && clr_valid;
    assign w_sel_ch    = w_clr ? cfg_ch : in_ch;
    assign w_cfg_shift = (cfg_shift > SH_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : cfg_shift;

    always_comb begin
        w_state_d    = r_state_q;
        w_init_cnt_d = r_init_cnt_q;
        case (r_state_q)
            INIT: begin
                w_init_cnt_d = r_init_cnt_q + 1'b1;
                if (r_init_cnt_q == CH_W'(NCH - 1)) begin
                    w_state_d    = RUN;
                    w_init_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // The stage snapshot takes the shift before this edge's cfg write lands.
    always_comb begin
        w_shift_d = r_shift_q;
        if (cfg_we) begin
            w_shift_d[cfg_ch] = w_cfg_shift;
        end
        w_s1_d.valid  = w_accept || w_clr;
        w_s1_d.is_clr = w_clr;
        w_s1_d.ch     = w_sel_ch;
        w_s1_d.u      = w_clr ? '0 : in_data;
        w_s1_d.shift  = r_shift_q[w_sel_ch];
    end

    assign w_wr_en   = (r_state_q == INIT) || r_s2_valid_q;
    assign w_wr_addr = (r_state_q == INIT) ? r_init_cnt_q : r_s2_ch_q;
    assign w_wr_data = (r_state_q == INIT) ? '0 : r_s2_sum_q;

    lowpass_mc_acc_mem #(
        .NCH     (NCH)
    ) u_acc_mem (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data),
        .rd_addr (r_s1_q.ch),
        .rd_data (w_rd_data)
    );

    assign w_sum_new = r_s1_q.is_clr ? '0
                     : (w_rd_data + ACC_W'(r_s1_q.u) - (w_rd_data >> r_s1_q.shift));

`ifdef LOWPASS_MC_ROUND_EN
    logic [ACC_W:0] w_rnd_bias;
    logic [ACC_W:0] w_rnd_sum;
    logic [ACC_W:0] w_rnd_q;

    always_comb begin
        w_rnd_bias = '0;
        if (r_s2_shift_q != '0) begin
            w_rnd_bias = (ACC_W+1)'(1) << (r_s2_shift_q - 1'b1);
        end
        w_rnd_sum = {1'b0, r_s2_sum_q} + w_rnd_bias;
        w_rnd_q   = w_rnd_sum >> r_s2_shift_q;
        w_result  = (|w_rnd_q[ACC_W:WIDTH]) ? '1 : w_rnd_q[WIDTH-1:0];
    end
`else
    assign w_result = WIDTH'(r_s2_sum_q >> r_s2_shift_q);
`endif

    always_comb begin
        w_out_valid_d = r_s2_valid_q && !r_s2_clr_q;
        w_out_ch_d    = r_out_ch_q;
        w_out_data_d  = r_out_data_q;
        if (w_out_valid_d) begin
            w_out_ch_d   = r_s2_ch_q;
            w_out_data_d = w_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= INIT;
            r_init_cnt_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_shift_q[i] <= SH_W'(DEFAULT_SHIFT);
            end
            r_s1_q        <= '0;
            r_s2_valid_q  <= 1'b0;
            r_s2_clr_q    <= 1'b0;
            r_s2_ch_q     <= '0;
            r_s2_shift_q  <= '0;
            r_s2_sum_q    <= '0;
            r_out_valid_q <= 1'b0;
            r_out_ch_q    <= '0;
            r_out_data_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_init_cnt_q  <= w_init_cnt_d;
            r_shift_q     <= w_shift_d;
            r_s1_q        <= w_s1_d;
            r_s2_valid_q  <= r_s1_q.valid;
            r_s2_clr_q    <= r_s1_q.is_clr;
            r_s2_ch_q     <= r_s1_q.ch;
            r_s2_shift_q  <= r_s1_q.shift;
            r_s2_sum_q    <= w_sum_new;
            r_out_valid_q <= w_out_valid_d;
            r_out_ch_q    <= w_out_ch_d;
            r_out_data_q  <= w_out_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lowpass_mc.sv
// ============================================================================
// Module      : tb_lowpass_mc
// Description : Scoreboard bench for lowpass_mc against a sequential
//               per-channel model (honours LOWPASS_MC_ROUND_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lowpass_mc;

    localparam int WIDTH         = 30;
    localparam int NCH           = 8;
    localparam int MAX_SHIFT     = 16;
    localparam int DEFAULT_SHIFT = 16;
    localparam int ACC_W         = WIDTH + MAX_SHIFT;
    localparam int CH_W          = 3;
    localparam int SH_W          = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CH_W-1:0]  in_ch = '0;
    logic [WIDTH-1:0] in_data = '0;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [SH_W-1:0]  cfg_shift = '0;
    logic             clr_valid = 1'b0;
    logic             out_valid;
    logic [CH_W-1:0]  out_ch;
    logic [WIDTH-1:0] out_data;

    lowpass_mc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_shift (cfg_shift),
        .clr_valid (clr_valid),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        int               ch;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             sb_q [$];
    exp_t             mon_e;
    logic [ACC_W-1:0] m_sum   [NCH];
    int               m_shift [NCH];
    int               n_chk = 0;
    int               n_err = 0;
    int               cyc   = 0;
    int               n_out = 0;
    int               n_before;
    bit               run   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_step(input int ch, input logic [WIDTH-1:0] u);
        logic [ACC_W-1:0] s_new;
        logic [ACC_W:0]   r;
        int               s;
        s     = m_shift[ch];
        s_new = m_sum[ch] + ACC_W'(u) - (m_sum[ch] >> s);
        m_sum[ch] = s_new;
        r = {1'b0, s_new};
`ifdef LOWPASS_MC_ROUND_EN
        if (s != 0) r = r + ((ACC_W+1)'(1) << (s - 1));
        r = r >> s;
        if (r > (ACC_W+1)'({WIDTH{1'b1}})) return '1;
        return r[WIDTH-1:0];
`else
        r = r >> s;
        return r[WIDTH-1:0];
`endif
    endfunction

    // One cycle of stimulus; expectations are formed before the edge.
    task automatic drive(input bit v, input int ch, input int data,
                         input bit we, input int wch, input int wsh, input bit clr);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_ch     = CH_W'(ch);
        in_data   = WIDTH'(data);
        cfg_we    = we;
        cfg_ch    = CH_W'(wch);
        cfg_shift = SH_W'(wsh);
        clr_valid = clr;
        #1;
        check_eq("in_ready", in_ready, run && !clr);
        if (v && run && !clr) begin
            e.due  = cyc + 3;
            e.ch   = ch;
            e.data = model_step(ch, WIDTH'(data));
            sb_q.push_back(e);
        end
        if (clr && run) m_sum[wch] = '0;
        if (we) m_shift[wch] = (wsh > MAX_SHIFT) ? MAX_SHIFT : wsh;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) idle();
        check_eq("drain", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        clr_valid = 1'b0;
        cfg_we    = 1'b0;
        run       = 1'b0;
        sb_q.delete();
        for (int i = 0; i < NCH; i++) begin
            m_sum[i]   = '0;
            m_shift[i] = DEFAULT_SHIFT;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_ch", out_ch, 0);
        check_eq("rst_out_data", out_data, 0);
        for (int i = 0; i < NCH; i++) begin
            check_eq("init_ready", in_ready, 0);
            @(negedge clk);
            #1;
        end
        check_eq("run_ready", in_ready, 1);
        run = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check_eq("spurious_out", out_valid, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("out_ch", out_ch, mon_e.ch);
                    check_eq("out_data", out_data, mon_e.data);
                    check_eq("latency", cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Step response on ch3, then a first sample on untouched ch2.
        for (int i = 0; i < 20; i++) drive(1'b1, 3, 1000, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 2, 70000, 1'b0, 0, 0, 1'b0);
        drain();

        // Same channel on every cycle exercises forwarding.
        drive(1'b0, 0, 0, 1'b1, 5, 2, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b1, 5, 400, 1'b0, 0, 0, 1'b0);
        drain();

        // Pass-through, same-cycle config uses old shift, then clamp.
        drive(1'b0, 0, 0, 1'b1, 1, 0, 1'b0);
        drive(1'b1, 1, 12345, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 1, 777, 1'b1, 1, 3, 1'b0);
        drive(1'b1, 1, 800, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 6, 31, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 6, 1 << 20, 1'b0, 0, 0, 1'b0);
        drain();

        // Clear between samples, back-to-back and with a gap.
        drive(1'b0, 0, 0, 1'b1, 3, 1, 1'b0);
        drive(1'b1, 3, 1000, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 3, 1000, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 3, 5555, 1'b0, 3, 0, 1'b1);
        drive(1'b1, 3, 1000, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 3, 3000, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 3, 0, 1'b1);
        idle();
        drive(1'b1, 3, 1000, 1'b0, 0, 0, 1'b0);
        drain();

        // Reset with two samples in flight.
        drive(1'b1, 5, 400, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 4, 9999, 1'b0, 0, 0, 1'b0);
        n_before = n_out;
        do_reset();
        check_eq("rst_flush", n_out - n_before, 0);
        drive(1'b1, 1, 1 << 20, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 5, 1 << 20, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 3, 1 << 20, 1'b0, 0, 0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
